dtt_crossbar_switch: RTL and testbench

N_IN x N_OUT registered crossbar switch. Each input presents one word per cycle, tagged with a destination output index. Each output has an independent round-robin arbiter that picks one requesting input per cycle and registers that word to the output. The block sits between ingress ports and egress ports in the data-transfer fabric. It has no backpressure: inputs that lose arbitration are dropped for that cycle and the source must re-present them.

---
 rtl/dtt_xbar_pkg.sv | 13 +
 rtl/dtt_rr_arbiter.sv | 37 +++
 rtl/dtt_crossbar_switch.sv | 78 +++++++
 tb/tb_dtt_crossbar_switch.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dtt_xbar_pkg.sv
// Shared constants and helpers for the crossbar switch and its per-output arbiters.
package dtt_xbar_pkg;

    localparam int N_IN_DEF       = 4;
    localparam int N_OUT_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 32;

    // Width of an index into n items, never narrower than one bit.
    function automatic int dest_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dtt_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found scanning
// upward from ptr, wrapping back to index 0.
module dtt_rr_arbiter
    import dtt_xbar_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = dest_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    // Two passes give the wrap-around scan: indices at/above ptr, then below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_grant && req[i] && (i >= int'(ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                any_grant = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_grant && req[i] && (i < int'(ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtt_crossbar_switch.sv
// N_IN x N_OUT registered crossbar with an independent round-robin arbiter per
// output. No backpressure: words that lose arbitration are dropped.
module dtt_crossbar_switch
    import dtt_xbar_pkg::*;
#(
    parameter  int N_IN       = N_IN_DEF,
    parameter  int N_OUT      = N_OUT_DEF,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int DEST_WIDTH = dest_width(N_OUT)
) (
    input  logic                        clk,
    input  logic                        rst_n,      // active-high despite the name
    input  logic [N_IN*DATA_WIDTH-1:0]  in_data,
    input  logic [N_IN*DEST_WIDTH-1:0]  in_dest,
    input  logic [N_IN-1:0]             in_valid,
    output logic [N_OUT*DATA_WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]            out_valid
);

    localparam int PW = dest_width(N_IN);

    logic [N_IN-1:0]       req       [N_OUT];
    logic [N_IN-1:0]       grant     [N_OUT];
    logic [PW-1:0]         grant_idx [N_OUT];
    logic [PW-1:0]         ptr       [N_OUT];
    logic [N_OUT-1:0]      any_grant;
    logic [DATA_WIDTH-1:0] win_data  [N_OUT];

    // Destinations >= N_OUT match no output, so they raise no request.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                req[j][i] = in_valid[i] &&
                            (int'(in_dest[i*DEST_WIDTH +: DEST_WIDTH]) == j);
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_arb
        dtt_rr_arbiter #(.N(N_IN)) u_arb (
            .req       (req[j]),
            .ptr       (ptr[j]),
            .grant     (grant[j]),
            .grant_idx (grant_idx[j]),
            .any_grant (any_grant[j])
        );
    end

    // Grants are one-hot, so an AND-OR mux selects the winning word.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            win_data[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                win_data[j] = win_data[j] |
                              (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[j][i]}});
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                ptr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                out_valid[j] <= any_grant[j];
                if (any_grant[j]) begin
                    out_data[j*DATA_WIDTH +: DATA_WIDTH] <= win_data[j];
                    ptr[j] <= (grant_idx[j] == PW'(N_IN - 1)) ? '0 : grant_idx[j] + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dtt_crossbar_switch.sv
// Self-checking bench for dtt_crossbar_switch: vector table with expected
// outputs fed through a scoreboard queue, plus reset sequences.
module tb_dtt_crossbar_switch;

    localparam logic [31:0] D0 = 32'hAAAABBBB;
    localparam logic [31:0] D1 = 32'hCCCCDDDD;
    localparam logic [31:0] D2 = 32'hEEEEFFFF;
    localparam logic [31:0] D3 = 32'h11112222;

    typedef struct packed {
        logic [3:0]   valid;
        logic [7:0]   dest;
        logic [127:0] data;
        logic [3:0]   exp_valid;
        logic [127:0] exp_data;
    } vec_t;

    typedef struct packed {
        int           id;
        logic [3:0]   ev;
        logic [127:0] ed;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [7:0]   in_dest;
    logic [3:0]   in_valid;
    logic [127:0] out_data;
    logic [3:0]   out_valid;

    vec_t vecs [12];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dtt_crossbar_switch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] v, input int d0, input int d1,
                                input int d2, input int d3, input logic [3:0] ev,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t r;
        r.valid     = v;
        r.dest      = {2'(d3), 2'(d2), 2'(d1), 2'(d0)};
        r.data      = {D3, D2, D1, D0};
        r.exp_valid = ev;
        r.exp_data  = {e3, e2, e1, e0};
        return r;
    endfunction

    task automatic check_vs(input string name, input logic [3:0] ev, input logic [127:0] ed);
        n_checks++;
        if (out_valid !== ev) begin
            n_fail++;
            $display("FAIL %s out_valid got %b want %b", name, out_valid, ev);
        end
        n_checks++;
        if (out_data !== ed) begin
            n_fail++;
            $display("FAIL %s out_data got %h want %h", name, out_data, ed);
        end
    endtask

    task automatic apply(input int idx);
        exp_t e;
        @(negedge clk);
        in_valid = vecs[idx].valid;
        in_dest  = vecs[idx].dest;
        in_data  = vecs[idx].data;
        e.id = idx;
        e.ev = vecs[idx].exp_valid;
        e.ed = vecs[idx].exp_data;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard empty got 0 entries want 1");
        end else begin
            e = sb_q.pop_front();
            check_vs($sformatf("vec%0d", e.id), e.ev, e.ed);
        end
    endtask

    initial begin
        // Pointers: all 0 after reset. Comments track ptr[out] after each vector.
        vecs[0]  = mk(4'b0011, 2, 2, 0, 0, 4'b0100, 0,  0,  D0, 0);   // p2=1
        vecs[1]  = mk(4'b0011, 2, 2, 0, 0, 4'b0100, 0,  0,  D1, 0);   // p2=2
        vecs[2]  = mk(4'b0011, 2, 2, 0, 0, 4'b0100, 0,  0,  D0, 0);   // p2=1
        vecs[3]  = mk(4'b0011, 2, 2, 0, 0, 4'b0100, 0,  0,  D1, 0);   // p2=2
        vecs[4]  = mk(4'b1111, 2, 2, 1, 3, 4'b1110, 0,  D2, D0, D3);  // p1=3 p2=1 p3=0
        vecs[5]  = mk(4'b1111, 3, 2, 1, 0, 4'b1111, D3, D2, D1, D0);  // p0=0 p1=3 p2=2 p3=1
        vecs[6]  = mk(4'b0000, 0, 0, 0, 0, 4'b0000, D3, D2, D1, D0);
        vecs[6].data = '0;
        vecs[7]  = mk(4'b0100, 0, 0, 0, 0, 4'b0001, D2, D2, D1, D0);  // p0=3
        vecs[8]  = mk(4'b1001, 0, 0, 0, 0, 4'b0001, D3, D2, D1, D0);  // wrap: in3, p0=0
        vecs[9]  = mk(4'b1001, 0, 0, 0, 0, 4'b0001, D0, D2, D1, D0);  // in0, p0=1
        vecs[10] = mk(4'b1001, 3, 0, 0, 3, 4'b1000, D0, D2, D1, D3);  // p3=1 -> in3
        // After async reset: p2 back to 0 picks in1 (a stale p2=2 would pick in3).
        vecs[11] = mk(4'b1010, 0, 2, 0, 2, 4'b0100, 0,  0,  D1, 0);

        rst_n    = 1'b1;
        in_valid = 4'b1111;
        in_dest  = 8'b11_10_01_00;
        in_data  = {D3, D2, D1, D0};
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check_vs($sformatf("reset_hold%0d", c), 4'b0000, 128'd0);
            @(negedge clk);
            in_valid = ~in_valid;
            in_dest  = ~in_dest;
        end
        in_valid = 4'b0000;
        rst_n    = 1'b0;

        for (int k = 0; k < 11; k++) apply(k);

        // Async reset between edges: outputs must clear before any clock edge.
        #2;
        rst_n    = 1'b1;
        in_valid = 4'b0000;
        #1;
        check_vs("async_reset", 4'b0000, 128'd0);
        @(negedge clk);
        rst_n = 1'b0;

        apply(11);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard leftover got %0d entries want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
